// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through, write-allocate data cache with one-word lines, an invalidate sweep
// after reset/flush, and blocking miss/write handling through a valid/ack backing-memory port.
`timescale 1ns/1ps
module dm_cache_ctrl #(
   parameter int ADDR_W  = 15,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              flush,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
);

   localparam int TAG_W  = ADDR_W - INDEX_W;
   localparam int LINE_W = TAG_W + DATA_W;
   localparam int LINES  = 1 << INDEX_W;

   localparam logic [2:0] S_INIT   = 3'd0;
   localparam logic [2:0] S_IDLE   = 3'd1;
   localparam logic [2:0] S_LOOKUP = 3'd2;
   localparam logic [2:0] S_MEM_RD = 3'd3;
   localparam logic [2:0] S_MEM_WR = 3'd4;

   logic [2:0]         state;
   logic [INDEX_W-1:0] init_idx;
   logic               flush_pending;
   logic [LINES-1:0]   valid;

   logic               lat_we;
   logic [ADDR_W-1:0]  lat_addr;
   logic [DATA_W-1:0]  lat_wdata;
   logic               lookup_hit_q;

   logic [LINE_W-1:0]  line_arr [LINES];
   logic [LINE_W-1:0]  line_q;

   logic [INDEX_W-1:0] lat_idx;
   logic [TAG_W-1:0]   lat_tag;
   logic [TAG_W-1:0]   line_tag;
   logic [DATA_W-1:0]  line_data;
   logic               lookup_hit;
   logic               accept;

   logic               arr_we;
   logic               arr_re;
   logic [INDEX_W-1:0] arr_idx;
   logic [LINE_W-1:0]  arr_wdat;

   // A same-cycle flush wins over the request, so ready must not advertise acceptance then.
   assign req_ready = (state == S_IDLE) && !flush_pending && !flush;
   assign accept    = req_valid && req_ready;

   assign mem_rd    = (state == S_MEM_RD);
   assign mem_wr    = (state == S_MEM_WR);
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

   assign lat_idx    = lat_addr[INDEX_W-1:0];
   assign lat_tag    = lat_addr[ADDR_W-1:INDEX_W];
   assign line_tag   = line_q[LINE_W-1:DATA_W];
   assign line_data  = line_q[DATA_W-1:0];
   assign lookup_hit = valid[lat_idx] && (line_tag == lat_tag);

   // Single-port line array: read at acceptance, written on write lookup or miss fill.
   always_comb begin
      arr_we   = 1'b0;
      arr_re   = 1'b0;
      arr_idx  = lat_idx;
      arr_wdat = {lat_tag, lat_wdata};
      if (state == S_IDLE) begin
         arr_idx = req_addr[INDEX_W-1:0];
         arr_re  = accept;
      end else if (state == S_LOOKUP) begin
         arr_we = lat_we;
      end else if (state == S_MEM_RD) begin
         arr_we   = mem_ack;
         arr_wdat = {lat_tag, mem_rdata};
      end
   end

   always_ff @(posedge clk) begin
      if (arr_we) begin
         line_arr[arr_idx] <= arr_wdat;
      end else if (arr_re) begin
         line_q <= line_arr[arr_idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_INIT;
         init_idx      <= '0;
         flush_pending <= 1'b0;
         valid         <= '0;
         lat_we        <= 1'b0;
         lat_addr      <= '0;
         lat_wdata     <= '0;
         lookup_hit_q  <= 1'b0;
         resp_valid    <= 1'b0;
         resp_hit      <= 1'b0;
         resp_rdata    <= '0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (flush && (state != S_IDLE)) begin
            flush_pending <= 1'b1;
         end

         case (state)
            S_INIT: begin
               valid[init_idx] <= 1'b0;
               init_idx        <= init_idx + INDEX_W'(1);
               if (&init_idx) begin
                  state <= S_IDLE;
                  if (!flush) begin
                     flush_pending <= 1'b0;
                  end
               end
            end

            S_IDLE: begin
               if (flush_pending || flush) begin
                  state         <= S_INIT;
                  init_idx      <= '0;
                  flush_pending <= 1'b0;
               end else if (req_valid) begin
                  lat_we    <= req_we;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  state     <= S_LOOKUP;
               end
            end

            S_LOOKUP: begin
               lookup_hit_q <= lookup_hit;
               if (lookup_hit) begin
                  hit_cnt <= hit_cnt + 32'd1;
               end else begin
                  miss_cnt <= miss_cnt + 32'd1;
               end
               if (lat_we) begin
                  valid[lat_idx] <= 1'b1;
                  state          <= S_MEM_WR;
               end else if (lookup_hit) begin
                  resp_valid <= 1'b1;
                  resp_hit   <= 1'b1;
                  resp_rdata <= line_data;
                  state      <= S_IDLE;
               end else begin
                  state <= S_MEM_RD;
               end
            end

            S_MEM_RD: begin
               if (mem_ack) begin
                  valid[lat_idx] <= 1'b1;
                  resp_valid     <= 1'b1;
                  resp_hit       <= 1'b0;
                  resp_rdata     <= mem_rdata;
                  state          <= S_IDLE;
               end
            end

            S_MEM_WR: begin
               if (mem_ack) begin
                  resp_valid <= 1'b1;
                  resp_hit   <= lookup_hit_q;
                  resp_rdata <= lat_wdata;
                  state      <= S_IDLE;
               end
            end

            default: begin
               state    <= S_INIT;
               init_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed plus randomized bench for dm_cache_ctrl against a line-level cache model and a 2-cycle-ack memory.
`timescale 1ns/1ps
module tb_dm_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [6:0]  req_addr;
   logic [31:0] req_wdata;
   logic        flush;
   logic        resp_valid;
   logic        resp_hit;
   logic [31:0] resp_rdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [6:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   dm_cache_ctrl #(.ADDR_W(7), .DATA_W(32), .INDEX_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] bmem    [128];
   logic [31:0] ref_mem [128];
   logic        mv      [16];
   logic [2:0]  mt      [16];
   int          exp_hits = 0;
   int          exp_misses = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model_lines();
      for (int i = 0; i < 16; i++) mv[i] = 1'b0;
   endtask

   // Backing memory: acknowledges in the second cycle a request is held.
   initial begin
      int wcnt;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      wcnt      = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst || !(mem_rd || mem_wr) || mem_ack) begin
            mem_ack = 1'b0;
            wcnt    = 0;
         end else begin
            wcnt++;
            if (wcnt == 2) begin
               mem_ack = 1'b1;
               if (mem_wr) bmem[mem_addr] = mem_wdata;
               else        mem_rdata = bmem[mem_addr];
            end
         end
      end
   end

   task automatic wait_init(input int start_n, input int expected, input string tag);
      int n;
      bit saw;
      n   = start_n;
      saw = 1'b0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
         if (resp_valid) saw = 1'b1;
      end
      chk(tag, 32'(n), 32'(expected));
      chk({tag, "_noresp"}, 32'(saw), 32'd0);
   endtask

   task automatic do_req(input logic we, input logic [6:0] addr, input logic [31:0] wd,
                         input bit flush_mode);
      int          n, idx, tg;
      logic        exp_hit;
      logic [31:0] exp_rd;
      bit          saw_rd, saw_wr, mem_seen;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = 7'($urandom);
      req_wdata = $urandom;

      idx     = int'(addr) % 16;
      tg      = int'(addr) / 16;
      exp_hit = mv[idx] && (mt[idx] == 3'(tg));
      if (we) begin
         ref_mem[addr] = wd;
         exp_rd        = wd;
      end else begin
         exp_rd = ref_mem[addr];
      end
      if (exp_hit) exp_hits++;
      else         exp_misses++;
      if (we || !exp_hit) begin
         mv[idx] = 1'b1;
         mt[idx] = 3'(tg);
      end

      n        = 0;
      saw_rd   = 1'b0;
      saw_wr   = 1'b0;
      mem_seen = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (flush) flush = 1'b0;
         if ((mem_rd || mem_wr) && !mem_seen) begin
            mem_seen = 1'b1;
            chk("mem_addr", 32'(mem_addr), 32'(addr));
            if (mem_wr) chk("mem_wdata", mem_wdata, wd);
            if (flush_mode) flush = 1'b1;
         end
         saw_rd |= mem_rd;
         saw_wr |= mem_wr;
      end while (!resp_valid && n < 50);

      chk("resp_latency", 32'(n), (!we && exp_hit) ? 32'd2 : 32'd4);
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_hit", 32'(resp_hit), 32'(exp_hit));
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("mem_rd_used", 32'(saw_rd), 32'(!we && !exp_hit));
      chk("mem_wr_used", 32'(saw_wr), 32'(we));
      chk("hit_cnt", hit_cnt, 32'(exp_hits));
      chk("miss_cnt", miss_cnt, 32'(exp_misses));
      chk("ready_at_resp", 32'(req_ready), flush_mode ? 32'd0 : 32'd1);
      @(negedge clk);
      chk("resp_pulse", 32'(resp_valid), 32'd0);
      if (flush_mode) begin
         wait_init(1, 17, "flush_after_rd_init");
         clear_model_lines();
      end
   endtask

   initial begin
      int          n, tv, iv;
      logic [6:0]  a;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      flush     = 1'b0;
      for (int i = 0; i < 128; i++) begin
         bmem[i]    = $urandom;
         ref_mem[i] = bmem[i];
      end
      bmem[7'h25]    = 32'hDEADBEEF;
      ref_mem[7'h25] = 32'hDEADBEEF;
      clear_model_lines();

      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_hit", 32'(resp_hit), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_hit_cnt", hit_cnt, 32'd0);
      chk("rst_miss_cnt", miss_cnt, 32'd0);
      rst = 1'b0;
      wait_init(0, 16, "reset_init_len");

      do_req(1'b0, 7'h25, 32'h0, 1'b0);
      chk("cold_rdata_literal", resp_rdata, 32'hDEADBEEF);
      do_req(1'b0, 7'h25, 32'h0, 1'b0);
      do_req(1'b1, 7'h35, 32'h12345678, 1'b0);
      do_req(1'b0, 7'h35, 32'h0, 1'b0);
      chk("conflict_wr_hit_literal", hit_cnt, 32'd2);
      do_req(1'b0, 7'h25, 32'h0, 1'b0);
      do_req(1'b0, 7'h35, 32'h0, 1'b0);
      do_req(1'b0, 7'h10, 32'h0, 1'b1);
      chk("cnt_kept_hits", hit_cnt, 32'(exp_hits));
      chk("cnt_kept_misses", miss_cnt, 32'(exp_misses));
      do_req(1'b0, 7'h35, 32'h0, 1'b0);

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            wait_init(1, 17, "idle_flush_init_len");
            clear_model_lines();
         end else begin
            tv = int'($urandom_range(0, 7));
            iv = int'($urandom_range(0, 3));
            a  = 7'(tv * 16 + iv);
            do_req(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
         end
      end

      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 7'h4A;
      req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      while (!mem_wr && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_mem_wr_seen", 32'(mem_wr), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_mem_wr_drop", 32'(mem_wr), 32'd0);
      chk("rst_mid_mem_rd_low", 32'(mem_rd), 32'd0);
      @(negedge clk);
      chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
      chk("rst_mid_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      clear_model_lines();
      exp_hits   = 0;
      exp_misses = 0;
      wait_init(0, 16, "rst_mid_init_len");
      chk("rst_mid_hit_cnt", hit_cnt, 32'd0);
      chk("rst_mid_miss_cnt", miss_cnt, 32'd0);
      do_req(1'b0, 7'h4A, 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
